// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and default depth for the instruction memory loader
package imem_loader_pkg;

    localparam int DEFAULT_NUM_WORDS = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian program bytes into 32-bit instruction words
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic        word_full
);

    // Every lane is rewritten before a word is used, so the register is only cleared on a new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt                      <= byte_cnt + 2'd1;
        end
    end

    assign word_full = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program bytes into instruction memory and holds the core in reset until done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int LEN_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] word_idx;
    logic [LEN_W-1:0] len_q;
    logic             len_bad;
    logic             last_word;
    logic             clear;
    logic             inc;
    logic             accept;
    logic             word_full;
    logic [1:0]       byte_cnt;
    logic [31:0]      word;

    assign len_bad   = (load_len == '0) || (32'(load_len) > 32'(NUM_WORDS));
    assign last_word = (word_idx == len_q - LEN_W'(1));
    assign accept    = byte_valid && byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        inc        = 1'b0;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b1;
        case (state)
            IDLE, DONE, ERR: begin
                done     = (state == DONE);
                err      = (state == ERR);
                core_rst = (state != DONE);
                if (start) begin
                    if (len_bad) begin
                        state_next = ERR;
                    end else begin
                        state_next = RECV;
                        clear      = 1'b1;
                    end
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                    inc        = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The length is latched at start so later changes on load_len cannot shorten a load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            len_q    <= '0;
        end else if (clear) begin
            word_idx <= '0;
            len_q    <= load_len;
        end else if (inc) begin
            word_idx <= word_idx + LEN_W'(1);
        end
    end

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (word),
        .byte_cnt  (byte_cnt),
        .word_full (word_full)
    );

    assign imem_addr  = 32'({word_idx, 2'b00});
    assign imem_wdata = word;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: NUM_WORDS, 64, instruction memory depth in 32-bit words.
REQ-002 Parameter: LEN_W, 7, width of the word-count input (must hold NUM_WORDS).
REQ-003 Port: clk  input  1  single clock, rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to begin a program load.
REQ-006 Port: load_len  input  LEN_W  number of words to load, sampled when start is accepted.
REQ-007 Port: byte_valid  input  1  byte_data holds a valid program byte.
REQ-008 Port: byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: imem_we  output  1  instruction memory write strobe.
REQ-011 Port: imem_addr  output  32  instruction memory byte address.
REQ-012 Port: imem_wdata  output  32  assembled instruction word.
REQ-013 Port: core_rst  output  1  holds the processor core in reset while high.
REQ-014 Port: busy  output  1  a load is in progress.
REQ-015 Port: done  output  1  the last load completed successfully.
REQ-016 Port: err  output  1  the last start request was rejected.

Function
REQ-017 The FSM SHALL have the states IDLE, RECV, WRITE, DONE and ERR.
REQ-018 In IDLE, a start with load_len == 0 or load_len > NUM_WORDS SHALL move the FSM to ERR; any other start SHALL move it to RECV, clearing the byte and word counters.
REQ-019 A byte SHALL be accepted only when byte_valid && byte_ready; byte_ready SHALL be high only in RECV.
REQ-020 The k-th accepted byte of a word (k = 0..3) SHALL be stored in imem_wdata[8k+7:8k].
REQ-021 Acceptance of the 4th byte SHALL move the FSM to WRITE; imem_we SHALL be high for exactly the following cycle.
REQ-022 During that cycle, imem_addr SHALL equal word_idx*4 and imem_wdata SHALL hold the complete word.
REQ-023 After WRITE, the FSM SHALL go to DONE if word_idx == load_len-1; otherwise word_idx SHALL increment and the FSM SHALL return to RECV.
REQ-024 The peak rate SHALL be one word per 5 cycles; gaps in byte_valid SHALL stall the loader without error or timeout.
REQ-025 start SHALL be ignored in RECV and WRITE.
REQ-026 A start in DONE or ERR SHALL be evaluated as in IDLE (REQ-018).
REQ-027 core_rst SHALL be low only in DONE; it SHALL go high in the cycle after a start is accepted in DONE.
REQ-028 busy SHALL be high in RECV and WRITE; done SHALL be high only in DONE; err SHALL be high only in ERR.
REQ-029 imem_we SHALL be low in every state except WRITE.
REQ-030 A partial word (fewer than 4 bytes) SHALL never be written.

Reset
REQ-031 While rst is high, the FSM SHALL be in IDLE and all counters and the assembly register SHALL be zero.
REQ-032 While rst is high: core_rst=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0.
REQ-033 Reset during RECV or WRITE SHALL discard the partial word, and no write strobe SHALL be issued after rst rises.

Structure
REQ-034 The FSM state encoding and the default NUM_WORDS SHALL reside in a shared package or header (imem_loader_pkg).
REQ-035 Byte-lane assembly and the 2-bit byte counter SHALL be one sub-module, word_assembler; the FSM and word counter SHALL stay in imem_loader.

Verification
REQ-036 Reset: assert rst mid-cycle -> core_rst=1, byte_ready=0, imem_we=0, done=0, err=0 immediately.
REQ-037 load_len=2; bytes 13 00 00 00 93 00 10 00 back-to-back -> writes addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093 -> done=1, core_rst=0.
REQ-038 Same stream with byte_valid low for 3 cycles between bytes -> identical two writes, no extra strobes.
REQ-039 start with load_len=0, then with load_len=65 (NUM_WORDS=64) -> err=1, core_rst=1, no imem_we.
REQ-040 rst pulse after 6 bytes of a 2-word load -> no write for word 1; a new start reloads from addr 0x0.
REQ-041 start pulsed during RECV -> ignored; start in DONE -> core_rst=1 next cycle and the load restarts at addr 0x0.
